// File: rtl/crc_pkg.sv
// Shared constants and FSM state type for the serial CRC-8 checker and generator.
package crc_pkg;

  localparam int CRC_W = 8;
  localparam int CNT_W = $clog2(CRC_W);

  localparam logic [CRC_W-1:0] CRC_SEED_DEF = 8'hD8;
  localparam logic [CRC_W-1:0] CRC_TAPS_DEF = 8'hC4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CHECK,
    S_REPORT
  } crc_state_e;

endpackage

// File: rtl/crc8_lfsr.sv
// CRC-8 LFSR register with seed load, message step and zero-fill shift controls.
// load_i together with step_i steps from SEED, so a frame starts in a single cycle.
module crc8_lfsr
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] SEED = CRC_SEED_DEF,
  parameter logic [CRC_W-1:0] TAPS = CRC_TAPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             shift_i,
  input  logic             data_i,
  output logic [CRC_W-1:0] lfsr_o
);

  logic [CRC_W-1:0] lfsr_q;
  logic [CRC_W-1:0] lfsr_d;
  logic [CRC_W-1:0] lfsrBase;
  logic             feedback;

  // Step wins over shift; the top never requests both in one cycle.
  always_comb begin
    lfsrBase = load_i ? SEED : lfsr_q;
    feedback = lfsrBase[0] ^ data_i;
    lfsr_d   = lfsrBase;
    if (step_i) begin
      lfsr_d          = (lfsrBase >> 1) ^ (feedback ? TAPS : '0);
      lfsr_d[CRC_W-1] = feedback;
    end else if (shift_i) begin
      lfsr_d = lfsrBase >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/crc_checker.sv
// Serial CRC-8 frame checker: message bits through the LFSR, then compares received CRC bits LSB first.
// Optional saturating error counter port err_cnt is built only with CRC_CHK_ERRCNT_EN defined.
module crc_checker
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] SEED = CRC_SEED_DEF,
  parameter logic [CRC_W-1:0] TAPS = CRC_TAPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DATA,
  input  logic             Active,
  input  logic             CRC_IN,
  input  logic             CRC_VALID,
  output logic             crc_done,
  output logic             crc_ok,
  output logic             crc_err
`ifdef CRC_CHK_ERRCNT_EN
  ,
  output logic [CRC_W-1:0] err_cnt
`endif
);

  crc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flag_q;
  logic             done_q;
  logic             ok_q;
  logic             err_q;

  logic             lfsrLoad;
  logic             lfsrStep;
  logic             lfsrShift;
  logic [CRC_W-1:0] lfsrVal;
  logic             unusedLfsrHi;
  logic             checkBit;
  logic             lastBit;
  logic             frameBad;

  // Active always wins: it restarts a frame from any state except DATA, where it just steps.
  always_comb begin
    lfsrLoad  = 1'b0;
    lfsrStep  = 1'b0;
    lfsrShift = 1'b0;
    if (Active) begin
      lfsrStep = 1'b1;
      lfsrLoad = (state_q != S_DATA);
    end else if (checkBit) begin
      lfsrShift = 1'b1;
    end
  end

  assign checkBit     = (state_q == S_CHECK) && !Active && CRC_VALID;
  assign lastBit      = checkBit && (cnt_q == CNT_W'(CRC_W - 1));
  assign frameBad     = flag_q | (CRC_IN ^ lfsrVal[0]);
  assign unusedLfsrHi = ^lfsrVal[CRC_W-1:1];

  crc8_lfsr #(
    .SEED(SEED),
    .TAPS(TAPS)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsrLoad),
    .step_i (lfsrStep),
    .shift_i(lfsrShift),
    .data_i (DATA),
    .lfsr_o (lfsrVal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Active) state_q <= S_DATA;
        end
        S_DATA: begin
          if (!Active) begin
            state_q <= S_CHECK;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (Active) begin
            state_q <= S_DATA;
          end else if (CRC_VALID) begin
            cnt_q  <= cnt_q + 1'b1;
            flag_q <= frameBad;
            // The result registers here so REPORT and the pulse share the same cycle.
            if (lastBit) begin
              state_q <= S_REPORT;
              done_q  <= 1'b1;
              ok_q    <= !frameBad;
              err_q   <= frameBad;
            end
          end
        end
        S_REPORT: begin
          state_q <= Active ? S_DATA : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign crc_done = done_q;
  assign crc_ok   = ok_q;
  assign crc_err  = err_q;

`ifdef CRC_CHK_ERRCNT_EN
  logic [CRC_W-1:0] errCnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      errCnt_q <= '0;
    end else if (lastBit && frameBad && (errCnt_q != '1)) begin
      errCnt_q <= errCnt_q + 1'b1;
    end
  end

  assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: expected results are queued as frames are driven and popped on crc_done.
module tb_crc_checker;

  typedef struct {
    logic  ok;
    logic  err;
    int    cycle;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic DATA;
  logic Active;
  logic CRC_IN;
  logic CRC_VALID;
  logic crc_done;
  logic crc_ok;
  logic crc_err;
`ifdef CRC_CHK_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  logic [7:0] errModel    = 8'h00;

  crc_checker dut (
    .clk      (clk),
    .rst      (rst),
    .DATA     (DATA),
    .Active   (Active),
    .CRC_IN   (CRC_IN),
    .CRC_VALID(CRC_VALID),
    .crc_done (crc_done),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err)
`ifdef CRC_CHK_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] modelStep(input logic [7:0] s, input logic d);
    logic       fb;
    logic [7:0] r;
    fb = s[0] ^ d;
    r  = s >> 1;
    if (fb) r = r ^ 8'hC4;
    r[7] = fb;
    return r;
  endfunction

  function automatic logic [7:0] modelCrc(input logic [63:0] dbits, input int n);
    logic [7:0] s;
    s = 8'hD8;
    for (int i = 0; i < n; i++) s = modelStep(s, dbits[i]);
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    Active    = 1'b0;
    CRC_VALID = 1'b0;
    DATA      = 1'b0;
    CRC_IN    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; gapAt/abortAfter of -1 disable the CRC_VALID gap and the early abort.
  task automatic applyStimulus(input logic [63:0] dbits, input int n, input logic [7:0] crc,
                               input logic expOk, input int gapAt, input int gapLen,
                               input int abortAfter, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      Active    = 1'b1;
      DATA      = dbits[i];
      CRC_VALID = (i == 0);
      CRC_IN    = ~crc[0];
      @(posedge clk);
      #1;
    end
    Active    = 1'b0;
    DATA      = 1'b0;
    CRC_VALID = 1'b1;
    CRC_IN    = ~crc[0];
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) begin
      if (j == abortAfter) return;
      if (j == gapAt) begin
        CRC_VALID = 1'b0;
        repeat (gapLen) begin
          CRC_IN = ~CRC_IN;
          @(posedge clk);
          #1;
        end
      end
      CRC_VALID = 1'b1;
      CRC_IN    = crc[j];
      if (j == 7) begin
        e.ok    = expOk;
        e.err   = !expOk;
        e.cycle = cyc + 1;
        e.tag   = tag;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard side: every negedge checks pulse exclusivity and pops an expectation on crc_done.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      checkOutput("pulse_exclusive", {31'd0, ((crc_ok && crc_err) || (!crc_done && (crc_ok || crc_err)))}, 32'd0);
      if (crc_done === 1'b1) begin
        checkOutput("unexpected_done", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput({e.tag, "_ok"}, {31'd0, crc_ok}, {31'd0, e.ok});
          checkOutput({e.tag, "_err"}, {31'd0, crc_err}, {31'd0, e.err});
          checkOutput({e.tag, "_latency"}, cyc, e.cycle);
`ifdef CRC_CHK_ERRCNT_EN
          if (e.err && errModel != 8'hFF) errModel = errModel + 8'd1;
          checkOutput({e.tag, "_errcnt"}, {24'd0, err_cnt}, {24'd0, errModel});
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rdata;
    int          rlen;
    logic [7:0]  rcrc;

    rst       = 1'b0;
    DATA      = 1'b0;
    Active    = 1'b0;
    CRC_IN    = 1'b0;
    CRC_VALID = 1'b0;
    #12;
    checkOutput("reset_done", {31'd0, crc_done}, 32'd0);
    checkOutput("reset_ok", {31'd0, crc_ok}, 32'd0);
    checkOutput("reset_err", {31'd0, crc_err}, 32'd0);
`ifdef CRC_CHK_ERRCNT_EN
    checkOutput("reset_errcnt", {24'd0, err_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    idleCycles(2);

    applyStimulus(64'h0, 8, 8'h14, 1'b1, -1, 0, -1, "good_zero");
    idleCycles(2);
    applyStimulus(64'h0, 8, 8'h10, 1'b0, -1, 0, -1, "bad_bit2");
    idleCycles(2);
    applyStimulus(64'h0, 8, 8'h14, 1'b1, 4, 3, -1, "good_gap");
    idleCycles(2);

    applyStimulus(64'h0, 8, 8'h14, 1'b1, -1, 0, 5, "aborted");
    applyStimulus(64'h0, 8, 8'h14, 1'b1, -1, 0, -1, "after_abort");
    idleCycles(2);

    applyStimulus(64'h0, 8, 8'h14, 1'b1, -1, 0, 4, "reset_mid");
    CRC_VALID = 1'b0;
    rst       = 1'b0;
    #2;
    errModel = 8'h00;
    checkOutput("midreset_done", {31'd0, crc_done}, 32'd0);
    checkOutput("midreset_ok", {31'd0, crc_ok}, 32'd0);
    checkOutput("midreset_err", {31'd0, crc_err}, 32'd0);
`ifdef CRC_CHK_ERRCNT_EN
    checkOutput("midreset_errcnt", {24'd0, err_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    idleCycles(3);
    applyStimulus(64'h0, 8, 8'h14, 1'b1, -1, 0, -1, "after_reset");
    idleCycles(2);

    for (int i = 0; i < 6; i++) begin
      rdata = {$urandom, $urandom};
      rlen  = $urandom_range(8, 16);
      rcrc  = modelCrc(rdata, rlen);
      if (i % 2 == 1) rcrc = rcrc ^ (8'h01 << $urandom_range(0, 7));
      applyStimulus(rdata, rlen, rcrc, (i % 2 == 0), -1, 0, -1, "random");
    end
    idleCycles(2);

    for (int i = 0; i < 260; i++) begin
      applyStimulus(64'h0, 8, 8'h15, 1'b0, -1, 0, -1, "bad_run");
    end
    idleCycles(5);
`ifdef CRC_CHK_ERRCNT_EN
    checkOutput("errcnt_saturated", {24'd0, err_cnt}, 32'h0000_00FF);
`endif
    checkOutput("pending_results", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
